// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (BUSY, HOLD, DRAIN), 2-bit encoding
//   pc_sel_t      : next-PC source select for pc_register
//   PC_INC        : sequential PC increment
//   RESET_PC_DEFAULT : default PC loaded on reset
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BUSY  = 2'd0,  // request outstanding at pc_reg
    HOLD  = 2'd1,  // fetched word parked in buf_reg while frozen
    DRAIN = 2'd2   // waiting out a request made stale by a redirect
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_SEL_INC    = 2'd0,
    PC_SEL_BRANCH = 2'd1,
    PC_SEL_TGT    = 2'd2
  } pc_sel_t;

  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_pc_register.sv
// Program counter register with next-value mux.
//   clock       : rising-edge clock
//   reset       : synchronous active-high reset, loads RESET_PC
//   load        : update enable
//   sel         : next-value source (pc+4 / branch_addr / tgt)
//   branch_addr : redirect target from EX
//   tgt         : redirect target saved while draining
//   pc          : current PC
//   pc_inc      : pc + PC_INC (wraps modulo 2^len)
module pc_register
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned     len      = 32,
  parameter logic [len-1:0]  RESET_PC = len'(RESET_PC_DEFAULT)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load,
  input  pc_sel_t        sel,
  input  logic [len-1:0] branch_addr,
  input  logic [len-1:0] tgt,
  output logic [len-1:0] pc,
  output logic [len-1:0] pc_inc
);

  logic [len-1:0] pc_next;

  assign pc_inc = pc + len'(PC_INC);

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      PC_SEL_INC:    pc_next = pc_inc;
      PC_SEL_BRANCH: pc_next = branch_addr;
      PC_SEL_TGT:    pc_next = tgt;
      default:       pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   freez                 : hazard-unit freeze, IF must not advance
//   branch_taken/addr     : redirect from EX (priority over freez)
//   imem_req/addr         : instruction-memory request, address held until ready
//   imem_rdata/ready      : memory response, ready completes the request
//   pc_out                : delivered instruction address + 4
//   instruction_out       : delivered instruction
//   fetch_stall           : no valid instruction this cycle
//   flush_out             : IF/ID flush (mirrors branch_taken)
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned    len      = 32,
  parameter logic [len-1:0] RESET_PC = len'(RESET_PC_DEFAULT)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           freez,
  input  logic           branch_taken,
  input  logic [len-1:0] branch_addr,
  output logic           imem_req,
  output logic [len-1:0] imem_addr,
  input  logic [len-1:0] imem_rdata,
  input  logic           imem_ready,
  output logic [len-1:0] pc_out,
  output logic [len-1:0] instruction_out,
  output logic           fetch_stall,
  output logic           flush_out
);

  fetch_state_t   st;
  logic [len-1:0] tgt_reg;
  logic [len-1:0] buf_reg;
  logic [len-1:0] pc_reg;
  logic [len-1:0] pc_inc;
  logic           pc_load;
  pc_sel_t        pc_sel;
  logic           valid;

  pc_register #(
    .len      (len),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clock       (clock),
    .reset       (reset),
    .load        (pc_load),
    .sel         (pc_sel),
    .branch_addr (branch_addr),
    .tgt         (tgt_reg),
    .pc          (pc_reg),
    .pc_inc      (pc_inc)
  );

  // PC update decision; the pc_register applies reset on its own.
  always_comb begin
    pc_load = 1'b0;
    pc_sel  = PC_SEL_INC;
    case (st)
      BUSY: begin
        if (imem_ready && branch_taken) begin
          pc_load = 1'b1;
          pc_sel  = PC_SEL_BRANCH;
        end else if (imem_ready && !freez) begin
          pc_load = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_load = 1'b1;
          pc_sel  = PC_SEL_BRANCH;
        end else if (!freez) begin
          pc_load = 1'b1;
        end
      end
      DRAIN: begin
        // A redirect arriving in the same cycle the stale request retires
        // beats the saved target.
        if (imem_ready) begin
          pc_load = 1'b1;
          pc_sel  = branch_taken ? PC_SEL_BRANCH : PC_SEL_TGT;
        end
      end
      default: begin
        pc_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st      <= BUSY;
      tgt_reg <= '0;
      buf_reg <= '0;
    end else begin
      case (st)
        BUSY: begin
          if (imem_ready) begin
            if (!branch_taken && freez) begin
              buf_reg <= imem_rdata;
              st      <= HOLD;
            end
          end else if (branch_taken) begin
            tgt_reg <= branch_addr;
            st      <= DRAIN;
          end
        end
        HOLD: begin
          if (branch_taken || !freez) begin
            st <= BUSY;
          end
        end
        DRAIN: begin
          if (branch_taken) begin
            tgt_reg <= branch_addr;
          end
          if (imem_ready) begin
            st <= BUSY;
          end
        end
        default: begin
          st <= BUSY;
        end
      endcase
    end
  end

  assign valid = !reset && !branch_taken &&
                 ((st == BUSY && imem_ready) || st == HOLD);

  assign imem_req        = !reset && (st == BUSY || st == DRAIN);
  assign imem_addr       = pc_reg;
  assign fetch_stall     = !valid;
  assign flush_out       = !reset && branch_taken;
  assign pc_out          = reset ? '0 : pc_inc;
  assign instruction_out = reset ? '0 : ((st == HOLD) ? buf_reg : imem_rdata);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit. Stimulus pushes the expected delivered
// {pc_out, instruction_out} pairs into a queue; a monitor pops one entry on
// every cycle the DUT reports a valid instruction.
module tb_if_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic        clock;
  logic        reset;
  logic        freez;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        fetch_stall;
  logic        flush_out;
  logic [31:0] rd_mask;

  int unsigned checks;
  int unsigned failures;
  item_t       exp_q[$];

  if_fetch_unit #(
    .len      (32),
    .RESET_PC (32'h0)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .freez           (freez),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .fetch_stall     (fetch_stall),
    .flush_out       (flush_out)
  );

  // Memory returns a word derived from the address; rd_mask lets the bench
  // change the data while the unit is parked in HOLD.
  assign imem_rdata = imem_addr ^ K ^ rd_mask;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    item_t it;
    it.pc    = pc;
    it.instr = instr;
    exp_q.push_back(it);
  endtask

  // One cycle: drive inputs just after posedge, check at negedge.
  task automatic cyc(input logic rdy, input logic frz, input logic br,
                     input logic [31:0] ba, input logic [31:0] e_addr,
                     input logic e_req, input logic e_stall, input logic e_flush);
    imem_ready   = rdy;
    freez        = frz;
    branch_taken = br;
    branch_addr  = ba;
    @(negedge clock);
    chk("imem_addr",   imem_addr,          e_addr);
    chk("imem_req",    32'(imem_req),      32'(e_req));
    chk("fetch_stall", 32'(fetch_stall),   32'(e_stall));
    chk("flush_out",   32'(flush_out),     32'(e_flush));
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (fetch_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got pc 0x%08h instr 0x%08h expected none", pc_out, instruction_out);
      end else begin
        item_t it;
        it = exp_q.pop_front();
        chk("sb_pc_out", pc_out, it.pc);
        chk("sb_instruction_out", instruction_out, it.instr);
      end
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    freez        = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    imem_ready   = 1'b0;
    rd_mask      = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state: outputs gated even with ready and branch high.
    imem_ready   = 1'b1;
    branch_taken = 1'b1;
    @(negedge clock);
    chk("rst_imem_req",    32'(imem_req),    32'd0);
    chk("rst_fetch_stall", 32'(fetch_stall), 32'd1);
    chk("rst_flush_out",   32'(flush_out),   32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Zero-wait streaming.
    push(32'd4,  32'd0  ^ K); cyc(1, 0, 0, 0, 32'd0,  1, 0, 0);
    push(32'd8,  32'd4  ^ K); cyc(1, 0, 0, 0, 32'd4,  1, 0, 0);
    push(32'd12, 32'd8  ^ K); cyc(1, 0, 0, 0, 32'd8,  1, 0, 0);
    push(32'd16, 32'd12 ^ K); cyc(1, 0, 0, 0, 32'd12, 1, 0, 0);

    // Reset mid-wait: request at 16 outstanding, then reset.
    cyc(0, 0, 0, 0, 32'd16, 1, 1, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 32'd16, 0, 1, 0);
    reset = 1'b0;

    // Wait states: ready every third cycle.
    cyc(0, 0, 0, 0, 32'd0, 1, 1, 0);
    cyc(0, 0, 0, 0, 32'd0, 1, 1, 0);
    push(32'd4, 32'd0 ^ K); cyc(1, 0, 0, 0, 32'd0, 1, 0, 0);
    cyc(0, 0, 0, 0, 32'd4, 1, 1, 0);
    cyc(0, 0, 0, 0, 32'd4, 1, 1, 0);
    push(32'd8, 32'd4 ^ K); cyc(1, 0, 0, 0, 32'd4, 1, 0, 0);

    // Freeze on the ready cycle of addr 8; memory data changes while held.
    push(32'd12, 32'd8 ^ K); cyc(1, 1, 0, 0, 32'd8, 1, 0, 0);
    rd_mask = 32'h1111_1111;
    repeat (3) begin
      push(32'd12, 32'd8 ^ K); cyc(1, 1, 0, 0, 32'd8, 0, 0, 0);
    end
    push(32'd12, 32'd8 ^ K); cyc(1, 0, 0, 0, 32'd8, 0, 0, 0);
    rd_mask = '0;
    push(32'd16, 32'd12 ^ K); cyc(1, 0, 0, 0, 32'd12, 1, 0, 0);

    // Branch during wait: stale response discarded, then fetch target.
    cyc(0, 0, 1, 32'h100, 32'd16, 1, 1, 1);
    cyc(0, 0, 0, 0,       32'd16, 1, 1, 0);
    cyc(1, 0, 0, 0,       32'd16, 1, 1, 0);
    push(32'h104, 32'h100 ^ K); cyc(1, 0, 0, 0, 32'h100, 1, 0, 0);

    // Branch with freeze while in HOLD: branch wins.
    push(32'h108, 32'h104 ^ K); cyc(1, 1, 0, 0, 32'h104, 1, 0, 0);
    cyc(1, 1, 1, 32'h180, 32'h104, 0, 1, 1);
    push(32'h184, 32'h180 ^ K); cyc(1, 0, 0, 0, 32'h180, 1, 0, 0);

    // Back-to-back branches in DRAIN, latest wins; freez ignored in DRAIN.
    cyc(0, 0, 1, 32'h200, 32'h184, 1, 1, 1);
    cyc(0, 1, 1, 32'h300, 32'h184, 1, 1, 1);
    cyc(1, 1, 0, 0,       32'h184, 1, 1, 0);
    push(32'h304, 32'h300 ^ K); cyc(1, 0, 0, 0, 32'h300, 1, 0, 0);

    // Branch arriving with ready while draining goes straight to its target.
    cyc(0, 0, 1, 32'h400, 32'h304, 1, 1, 1);
    cyc(1, 0, 1, 32'h500, 32'h304, 1, 1, 1);
    push(32'h504, 32'h500 ^ K); cyc(1, 0, 0, 0, 32'h500, 1, 0, 0);

    // Branch on a ready cycle in BUSY: data discarded.
    cyc(1, 0, 1, 32'h600, 32'h504, 1, 1, 1);
    push(32'h604, 32'h600 ^ K); cyc(1, 0, 0, 0, 32'h600, 1, 0, 0);

    // PC wrap at the top of the address space.
    cyc(1, 0, 1, 32'hFFFF_FFFC, 32'h604, 1, 1, 1);
    push(32'h0, 32'hFFFF_FFFC ^ K); cyc(1, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 0);
    push(32'h4, 32'h0 ^ K);         cyc(1, 0, 0, 0, 32'h0,         1, 0, 0);

    imem_ready = 1'b0;
    @(negedge clock);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that writes the IF/ID pipeline register.
- Owns the PC and drives a request/ready instruction-memory port that may insert wait states.
- Presents pc and instruction to IF/ID with a stall indication, and honours the hazard unit's freeze and the branch redirect.
- Flush and stall outputs map one-to-one onto the IF/ID register's flush and freeze inputs.

Parameters:
- len, 32, width of PC, addresses and instruction words.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- freez  input  1  hazard-unit freeze; IF must not advance.
- branch_taken  input  1  redirect request from EX.
- branch_addr  input  len  redirect target.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  len  request address.
- imem_rdata  input  len  instruction data; valid when imem_ready=1.
- imem_ready  input  1  request completes this cycle.
- pc_out  output  len  address of delivered instruction + 4.
- instruction_out  output  len  delivered instruction.
- fetch_stall  output  1  no valid instruction this cycle; OR'ed into IF/ID freez.
- flush_out  output  1  IF/ID flush, equal to branch_taken.

Behaviour:
- State register st ∈ {BUSY, HOLD, DRAIN}. Other registers: pc_reg, tgt_reg, buf_reg.
- Reset (synchronous, active-high) sets st=BUSY, pc_reg=RESET_PC, tgt_reg=0, buf_reg=0.
- While reset=1: imem_req=0, fetch_stall=1, flush_out=0. pc_out and instruction_out are don't-care but must not be X.
- Reset dominates everything, including mid-wait. An outstanding memory request is abandoned, and the memory must tolerate req dropping.
- Memory protocol:
  - imem_req=1 in BUSY and DRAIN; imem_addr=pc_reg.
  - addr is held stable until imem_ready is sampled 1.
  - Zero-wait memories may assert ready in the first req cycle.
- valid = (st==BUSY && imem_ready) || st==HOLD, gated by !branch_taken.
- Output mapping:
  - fetch_stall = !valid.
  - instruction_out = imem_rdata in BUSY, buf_reg in HOLD.
  - pc_out = pc_reg + 4, modulo 2^len (wraps silently).
- Transitions (branch_taken has priority over freez):
  - BUSY, ready, branch: pc_reg<=branch_addr; stay BUSY; data discarded.
  - BUSY, ready, !branch, !freez: pc_reg<=pc_reg+4; stay BUSY. IF/ID loads this cycle, giving back-to-back fetch at 1 instr/cycle with zero-wait memory.
  - BUSY, ready, !branch, freez: buf_reg<=imem_rdata; go HOLD; pc_reg unchanged.
  - BUSY, !ready, branch: tgt_reg<=branch_addr; go DRAIN.
  - BUSY, !ready, !branch: stay BUSY.
  - HOLD, branch: pc_reg<=branch_addr; go BUSY.
  - HOLD, !branch, freez: stay HOLD; instruction stays presented.
  - HOLD, !branch, !freez: pc_reg<=pc_reg+4; go BUSY. IF/ID captures buf_reg this cycle.
  - DRAIN, branch: tgt_reg<=branch_addr, latest wins. If ready is also 1, go BUSY with pc_reg<=branch_addr.
  - DRAIN, !branch, ready: pc_reg<=tgt_reg; go BUSY; data discarded.
  - DRAIN, !branch, !ready: stay DRAIN.
- In DRAIN, fetch_stall=1 always.
- freez is ignored for PC update in DRAIN.
- Latency:
  - Branch to first target instruction at IF/ID input: 1 cycle with zero-wait memory.
  - Otherwise 1 cycle plus remaining wait states of the in-flight request plus the target's wait states.

Decomposition:
- Shared pipeline package holds:
  - state enumeration {BUSY, HOLD, DRAIN}, 2-bit;
  - constant PC_INC=4;
  - RESET_PC default.
- One natural sub-module, pc_register: len-bit register with synchronous reset to RESET_PC, load-enable, and next-value mux (pc+4 / branch_addr / tgt_reg).
- FSM and output muxing stay in if_fetch_unit.

Test Plan:
- Zero-wait streaming:
  - Stimulus: reset, then imem_ready=1 always, rdata=addr^32'hA5A5_0000, freez=0.
  - Response: imem_addr 0,4,8,12 on consecutive cycles; pc_out 4,8,12,16; fetch_stall=0 from first post-reset cycle.
- Wait states:
  - Stimulus: ready asserted every 3rd cycle.
  - Response: imem_addr held at 0 for 3 cycles; fetch_stall=1,1,0 pattern; pc_reg advances only on the ready cycle.
- Freeze on ready:
  - Stimulus: freez=1 for 4 cycles starting on the ready cycle of addr 8; rdata changes after.
  - Response: st=HOLD; instruction_out equals captured word for all 4 cycles; fetch_stall=0; imem_req=0. On release, pc_out=12, then next imem_addr=12.
- Branch during wait:
  - Stimulus: addr 16 outstanding; branch_taken=1, branch_addr=0x100 while ready=0; ready arrives 2 cycles later.
  - Response: flush_out=1 for one cycle; DRAIN; addr held 16; returned data discarded (fetch_stall=1); next imem_addr=0x100.
- Branch plus freeze, and back-to-back branches:
  - Stimulus: branch_taken=1 with freez=1 in HOLD; separately, two branches in DRAIN to 0x200 then 0x300.
  - Response: pc_reg=branch_addr, freeze ignored; after drain, fetch starts at 0x300.
- Reset mid-wait and wrap:
  - Stimulus: assert reset in BUSY with ready=0.
  - Response: next cycle imem_req=0, fetch_stall=1; after release imem_addr=RESET_PC.
  - Stimulus: pc_reg=0xFFFF_FFFC on a ready cycle.
  - Response: pc_out=0, next addr=0.
